// File: rtl/regfile_flags_if.sv
// ----------------------------------------------------------------------------
// regfile_flags_if
// Purpose : Bundles the register-file and flag-register signals that pass
//           between the datapath control (master) and the register file
//           (slave). Clock and reset are not part of the bundle.
// Signals :
//   ra_addr/ra_data, rb_addr/rb_data : ALU operand read ports A and B
//   we, wr_addr, wr_data             : register write port
//   flag_we {C,Z,N}, c_in, z_in, n_in: per-flag update
//   c_flag, z_flag, n_flag           : current flags (c_flag feeds ALU cin)
//   ptr_sel, ptr_data, ptr_inc       : 16-bit register-pair pointer path
//   int_save, int_restore            : shadow flag copy for interrupts
// Handshake: there is no valid/ready flow control. Every enable (we,
//   flag_we, ptr_inc, int_save, int_restore) is a single-cycle qualifier
//   sampled on the rising clock edge; read data is always valid.
// ----------------------------------------------------------------------------
interface regfile_flags_if #(
    parameter int AW = 4
);
    logic [AW-1:0] ra_addr;
    logic [7:0]    ra_data;
    logic [AW-1:0] rb_addr;
    logic [7:0]    rb_data;
    logic          we;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [2:0]    flag_we;
    logic          c_in;
    logic          z_in;
    logic          n_in;
    logic          c_flag;
    logic          z_flag;
    logic          n_flag;
    logic [AW-2:0] ptr_sel;
    logic [15:0]   ptr_data;
    logic          ptr_inc;
    logic          int_save;
    logic          int_restore;

    modport master (
        output ra_addr, rb_addr, we, wr_addr, wr_data,
        output flag_we, c_in, z_in, n_in,
        output ptr_sel, ptr_inc, int_save, int_restore,
        input  ra_data, rb_data, c_flag, z_flag, n_flag, ptr_data
    );

    modport slave (
        input  ra_addr, rb_addr, we, wr_addr, wr_data,
        input  flag_we, c_in, z_in, n_in,
        input  ptr_sel, ptr_inc, int_save, int_restore,
        output ra_data, rb_data, c_flag, z_flag, n_flag, ptr_data
    );
endinterface

// File: rtl/regfile_flags.sv
// ----------------------------------------------------------------------------
// regfile_flags
// Purpose : CPU register file (NREG x 8 bit) with two combinational read
//           ports, one write port, a 16-bit register-pair pointer with
//           post-increment, a {C,Z,N} status-flag register and a shadow
//           flag copy used on interrupt entry/return.
// Ports   :
//   clk_i-style scalars : clk (rising edge), rst (synchronous, active high)
//   bus                 : regfile_flags_if.slave, see interface header
// Optional feature (macro REGFILE_BYPASS_EN):
//   defined   -> write data forwarded combinationally to ra/rb/ptr bytes
//                when the address matches, and c_in forwarded to c_flag
//                when carry is being written and no restore is happening.
//   undefined -> all outputs come from registered state only.
// ----------------------------------------------------------------------------
module regfile_flags #(
    parameter int NREG = 16,
    parameter int AW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    regfile_flags_if.slave  bus
);

    logic [7:0] regs_q [NREG];
    logic [7:0] regs_d [NREG];

    logic [2:0] flags_q;   // {C,Z,N}
    logic [2:0] flags_d;
    logic [2:0] shadow_q;  // {C,Z,N}
    logic [2:0] shadow_d;

    // Register pair k is {reg[2k] (high), reg[2k+1] (low)}.
    logic [AW-1:0] hi_idx;
    logic [AW-1:0] lo_idx;
    logic [15:0]   ptr_cur;
    logic [15:0]   ptr_next;
    logic          wr_in_pair;
    logic          inc_ok;
    logic [2:0]    flags_upd;

    assign hi_idx   = {bus.ptr_sel, 1'b0};
    assign lo_idx   = {bus.ptr_sel, 1'b1};
    assign ptr_cur  = {regs_q[hi_idx], regs_q[lo_idx]};
    assign ptr_next = ptr_cur + 16'd1;

    // A write that lands in the selected pair wins and suppresses the
    // increment for both bytes, so the untouched byte keeps its old value.
    assign wr_in_pair = bus.we && (bus.wr_addr[AW-1:1] == bus.ptr_sel);
    assign inc_ok     = bus.ptr_inc && !wr_in_pair;

    always_comb begin
        regs_d = regs_q;
        if (inc_ok) begin
            regs_d[hi_idx] = ptr_next[15:8];
            regs_d[lo_idx] = ptr_next[7:0];
        end
        if (bus.we) begin
            regs_d[bus.wr_addr] = bus.wr_data;
        end
    end

    // Flag update: each bit independent, then restore overrides all three.
    always_comb begin
        flags_upd = flags_q;
        if (bus.flag_we[2]) flags_upd[2] = bus.c_in;
        if (bus.flag_we[1]) flags_upd[1] = bus.z_in;
        if (bus.flag_we[0]) flags_upd[0] = bus.n_in;

        flags_d  = bus.int_restore ? shadow_q : flags_upd;

        // Save captures the post-edge flags; with a simultaneous restore the
        // shadow instead takes the old flags, giving a swap.
        shadow_d = shadow_q;
        if (bus.int_save) begin
            shadow_d = bus.int_restore ? flags_q : flags_upd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q   <= '{default: '0};
            flags_q  <= 3'b000;
            shadow_q <= 3'b000;
        end else begin
            regs_q   <= regs_d;
            flags_q  <= flags_d;
            shadow_q <= shadow_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign bus.ra_data  = (bus.we && bus.ra_addr == bus.wr_addr) ? bus.wr_data
                                                                 : regs_q[bus.ra_addr];
    assign bus.rb_data  = (bus.we && bus.rb_addr == bus.wr_addr) ? bus.wr_data
                                                                 : regs_q[bus.rb_addr];
    assign bus.ptr_data = {(bus.we && hi_idx == bus.wr_addr) ? bus.wr_data : regs_q[hi_idx],
                           (bus.we && lo_idx == bus.wr_addr) ? bus.wr_data : regs_q[lo_idx]};
    assign bus.c_flag   = (bus.flag_we[2] && !bus.int_restore) ? bus.c_in : flags_q[2];
`else
    assign bus.ra_data  = regs_q[bus.ra_addr];
    assign bus.rb_data  = regs_q[bus.rb_addr];
    assign bus.ptr_data = ptr_cur;
    assign bus.c_flag   = flags_q[2];
`endif

    assign bus.z_flag = flags_q[1];
    assign bus.n_flag = flags_q[0];

endmodule

// File: tb/tb_regfile_flags.sv
module tb_regfile_flags;

    localparam int AW = 4;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    regfile_flags_if #(.AW(AW)) bus_if ();

    regfile_flags #(.NREG(16), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // advance one edge, sample 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.we          = 1'b0;
        bus_if.wr_addr     = '0;
        bus_if.wr_data     = '0;
        bus_if.flag_we     = 3'b000;
        bus_if.c_in        = 1'b0;
        bus_if.z_in        = 1'b0;
        bus_if.n_in        = 1'b0;
        bus_if.ptr_inc     = 1'b0;
        bus_if.int_save    = 1'b0;
        bus_if.int_restore = 1'b0;
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [7:0] d);
        bus_if.we = 1'b1; bus_if.wr_addr = a; bus_if.wr_data = d;
        tick();
        bus_if.we = 1'b0;
    endtask

    task automatic set_flags(input logic [2:0] we3, input logic [2:0] cZn);
        bus_if.flag_we = we3;
        {bus_if.c_in, bus_if.z_in, bus_if.n_in} = cZn;
        tick();
        bus_if.flag_we = 3'b000;
    endtask

    function automatic logic [15:0] flags_now();
        return {13'd0, bus_if.c_flag, bus_if.z_flag, bus_if.n_flag};
    endfunction

    task automatic read_reg(input logic [AW-1:0] a, output logic [7:0] d);
        bus_if.ra_addr = a;
        #1;
        d = bus_if.ra_data;
    endtask

    logic [7:0] rd;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        idle_inputs();
        bus_if.ra_addr = '0;
        bus_if.rb_addr = '0;
        bus_if.ptr_sel = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // reset state
        check_val("reset_flags", flags_now(), 16'h0000);
        read_reg(4'd3, rd);
        check_val("reset_r3", {8'd0, rd}, 16'h0000);

        // reset mid-operation discards write/increment
        write_reg(4'd3, 8'hA5);
        read_reg(4'd3, rd);
        check_val("write_r3", {8'd0, rd}, 16'h00A5);
        set_flags(3'b111, 3'b111);
        check_val("flags_all_set", flags_now(), 16'h0007);
        bus_if.ptr_sel = 3'd1;
        rst = 1'b1;
        bus_if.we = 1'b1; bus_if.wr_addr = 4'd3; bus_if.wr_data = 8'h77;
        bus_if.ptr_inc = 1'b1;
        bus_if.flag_we = 3'b111;
        tick();
        rst = 1'b0;
        idle_inputs();
        read_reg(4'd3, rd);
        check_val("rst_r3", {8'd0, rd}, 16'h0000);
        check_val("rst_flags", flags_now(), 16'h0000);
        check_val("rst_ptr1", bus_if.ptr_data, 16'h0000);

        // r0 is general purpose
        write_reg(4'd0, 8'h5A);
        read_reg(4'd0, rd);
        check_val("r0_gp", {8'd0, rd}, 16'h005A);

        // write and dual read, plus same-cycle read during write
        bus_if.ra_addr = 4'd5;
        bus_if.we = 1'b1; bus_if.wr_addr = 4'd5; bus_if.wr_data = 8'h3C;
        #1;
`ifdef REGFILE_BYPASS_EN
        check_val("same_cycle_r5", {8'd0, bus_if.ra_data}, 16'h003C);
`else
        check_val("same_cycle_r5", {8'd0, bus_if.ra_data}, 16'h0000);
`endif
        tick();
        bus_if.we = 1'b0;
        write_reg(4'd6, 8'hC3);
        bus_if.ra_addr = 4'd5;
        bus_if.rb_addr = 4'd6;
        #1;
        check_val("read_a_r5", {8'd0, bus_if.ra_data}, 16'h003C);
        check_val("read_b_r6", {8'd0, bus_if.rb_data}, 16'h00C3);

        // pointer wrap 0xFFFF -> 0x0000, carry unaffected
        write_reg(4'd14, 8'hFF);
        write_reg(4'd15, 8'hFF);
        bus_if.ptr_sel = 3'd7;
        #1;
        check_val("ptr_ffff", bus_if.ptr_data, 16'hFFFF);
        bus_if.ptr_inc = 1'b1;
        tick();
        bus_if.ptr_inc = 1'b0;
        check_val("ptr_wrap", bus_if.ptr_data, 16'h0000);
        check_val("ptr_carry", {15'd0, bus_if.c_flag}, 16'h0000);

        // 0x00FF -> 0x0100
        write_reg(4'd15, 8'hFF);
        check_val("ptr_00ff", bus_if.ptr_data, 16'h00FF);
        bus_if.ptr_inc = 1'b1;
        tick();
        bus_if.ptr_inc = 1'b0;
        check_val("ptr_0100", bus_if.ptr_data, 16'h0100);

        // conflict: write in pair wins, no increment
        write_reg(4'd14, 8'h12);
        write_reg(4'd15, 8'h34);
        bus_if.ptr_inc = 1'b1;
        bus_if.we = 1'b1; bus_if.wr_addr = 4'd15; bus_if.wr_data = 8'h80;
        tick();
        bus_if.we = 1'b0; bus_if.ptr_inc = 1'b0;
        check_val("ptr_conflict", bus_if.ptr_data, 16'h1280);

        // write outside the pair and increment together
        bus_if.ptr_inc = 1'b1;
        bus_if.we = 1'b1; bus_if.wr_addr = 4'd2; bus_if.wr_data = 8'h55;
        tick();
        bus_if.we = 1'b0; bus_if.ptr_inc = 1'b0;
        check_val("ptr_inc_parallel", bus_if.ptr_data, 16'h1281);
        read_reg(4'd2, rd);
        check_val("r2_parallel", {8'd0, rd}, 16'h0055);

        // independent flag update
        set_flags(3'b100, 3'b111);
        check_val("flag_c_only", flags_now(), 16'h0004);

        // save / write / restore
        set_flags(3'b111, 3'b101);
        bus_if.int_save = 1'b1; tick(); bus_if.int_save = 1'b0;
        set_flags(3'b111, 3'b010);
        check_val("flags_010", flags_now(), 16'h0002);
        bus_if.int_restore = 1'b1; tick(); bus_if.int_restore = 1'b0;
        check_val("restore_101", flags_now(), 16'h0005);

        // save together with flag write captures the new values
        bus_if.int_save = 1'b1;
        set_flags(3'b111, 3'b011);
        bus_if.int_save = 1'b0;
        check_val("save_new_flags", flags_now(), 16'h0003);
        set_flags(3'b111, 3'b000);
        // restore beats flag_we
        bus_if.int_restore = 1'b1;
        set_flags(3'b111, 3'b100);
        bus_if.int_restore = 1'b0;
        check_val("restore_priority", flags_now(), 16'h0003);

        // swap: shadow=111, flags=000
        set_flags(3'b111, 3'b111);
        bus_if.int_save = 1'b1; tick(); bus_if.int_save = 1'b0;
        set_flags(3'b111, 3'b000);
        bus_if.int_save = 1'b1; bus_if.int_restore = 1'b1;
        tick();
        bus_if.int_save = 1'b0; bus_if.int_restore = 1'b0;
        check_val("swap_flags", flags_now(), 16'h0007);
        bus_if.int_restore = 1'b1; tick(); bus_if.int_restore = 1'b0;
        check_val("swap_shadow", flags_now(), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
